seq_calc_alu: RTL and testbench
===============================

// Module: seq_calc_alu
// PURPOSE
//   Parametrised multi-cycle integer ALU for the calculator datapath. It computes add, subtract, multiply and divide on
//   W-bit unsigned operands, using iterative shift-add and restoring-divide engines.
//   Sits between the PicoVersat-side operand/opcode registers and the result encoder.
//   Adds to the previous ALU: start/done/busy handshake, subtract, divide-by-zero and illegal-op error flag, width param.
// PARAMETERS
//   W        4   operand width in bits (2..16); result width is 2*W
//   OPW      4   opcode width; one-hot encoding
// PORTS
//   clk              in   1      system clock, single domain
//   rst              in   1      synchronous, active-high reset
//   alu_sel          in   1      start request; accepted only with wr_enable=1 while idle
//   wr_enable        in   1      operand/opcode write qualifier
//   first_nr         in   W      operand A (unsigned)
//   second_nr        in   W      operand B (unsigned)
//   operation        in   OPW    0000 nop, 0001 add, 0010 mul, 0100 div, 1000 sub
//   result_uncoded   out  2*W    registered result; holds until next completion
//   alu_done         out  1      one-cycle pulse when result_uncoded/alu_err are updated
//   alu_busy         out  1      high from acceptance until the cycle alu_done pulses
//   alu_err          out  1      divide-by-zero or illegal opcode; valid with alu_done, held
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge): result_uncoded=0, alu_done=0, alu_busy=0, alu_err=0, FSM->IDLE.
//   Reset mid-operation aborts; no alu_done is produced for the aborted op.
//   FSM: IDLE -> (alu_sel & wr_enable) capture A,B,op -> EXEC -> FINISH -> IDLE.
//   Acceptance edge T0: operands/op latched, alu_busy=1.
//   Start while busy: ignored, no queueing, no effect on the running op.
//   Latency from T0:
//     add/sub/nop/illegal: result+alu_done at edge T0+2.
//     mul/div: EXEC runs W iterations, so result+alu_done at edge T0+W+2.
//     div by 0: does not iterate; completes at T0+2.
//   alu_busy falls on the same edge that alu_done rises. A new start may be accepted the cycle after alu_done
//   (back-to-back gap of one cycle).
//   Arithmetic (all unsigned inputs, 2*W-bit output):
//     add: zero-extended A+B (W+1 significant bits).
//     sub: A-B in 2*W-bit two's complement; negative results are sign-extended.
//     mul: full 2*W product via W shift-add steps.
//     div: restoring division with W steps; quotient in low W bits (upper bits per ALU_REM_EN).
//     div B=0: quotient all-ones, remainder = A, alu_err=1.
//     nop: result 0, alu_err=0.
//     illegal (non one-hot, nonzero): result 0, alu_err=1.
//   alu_err clears at the next completion without error; it is never set outside an alu_done pulse.
// CONFIGURATION
//   ALU_REM_EN defined:
//     div result = {remainder[W-1:0], quotient[W-1:0]}.
//     div-by-0 result = {A, all-ones}.
//   ALU_REM_EN undefined:
//     div result = {W'b0, quotient}; remainder logic is removed.
//   Latency and all other operations are unchanged either way.
// STRUCTURE
//   Package calc_alu_pkg:
//     opcode localparams OP_NOP/OP_ADD/OP_MUL/OP_DIV/OP_SUB
//     FSM state encodings ST_IDLE/ST_EXEC/ST_FINISH
//   Sub-module alu_iter_core: a shared shift register and W-step counter serving both mul (shift-add) and
//   div (shift-subtract). It has start/done ports and a mode select. Add/sub stay inline in seq_calc_alu.
// TESTING  (W=4 unless noted)
//   - add 7+5: result 8'h0C; alu_done pulses at T0+2; alu_err=0.
//   - sub 3-9: result 8'hFA. Then sub 9-3: result 8'h06.
//   - mul 15*15: result 8'hE1 with alu_done at T0+6. Assert alu_sel every cycle while busy; no second op starts.
//   - div 13/4:
//       ALU_REM_EN set: 8'h13.
//       ALU_REM_EN unset: 8'h03.
//   - div 9/0: alu_err=1 at T0+2, result 8'h9F (macro set) or 8'h0F (unset).
//     Then add 1+1: alu_err=0.
//   - rst=1 at T0+3 during mul: every output is 0 next edge, no alu_done.
//     A new start at the following cycle completes normally.
//     Repeat the mul cases with W=8: 255*255 = 16'hFE01 at T0+10.

Source files
------------

// File: rtl/seq_calc_alu_pkg.sv
// -----------------------------------------------------------------------------
// calc_alu_pkg
//   Shared opcode constants, FSM state type and iteration-engine mode type for
//   the sequential calculator ALU (seq_calc_alu and alu_iter_core).
//   Opcodes are one-hot; any other nonzero value is illegal.
// -----------------------------------------------------------------------------
package calc_alu_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_t;

endpackage

// File: rtl/seq_calc_alu_if.sv
// -----------------------------------------------------------------------------
// seq_calc_alu_if
//   Operand/opcode request and result bundle of the calculator ALU.
//   master : operand register side (drives alu_sel, wr_enable, first_nr,
//            second_nr, operation; receives result_uncoded, alu_done,
//            alu_busy, alu_err)
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface seq_calc_alu_if #(
    parameter int W   = 4,
    parameter int OPW = 4
);
    logic             alu_sel;
    logic             wr_enable;
    logic [W-1:0]     first_nr;
    logic [W-1:0]     second_nr;
    logic [OPW-1:0]   operation;
    logic [2*W-1:0]   result_uncoded;
    logic             alu_done;
    logic             alu_busy;
    logic             alu_err;

    modport master (
        output alu_sel, wr_enable, first_nr, second_nr, operation,
        input  result_uncoded, alu_done, alu_busy, alu_err
    );

    modport slave (
        input  alu_sel, wr_enable, first_nr, second_nr, operation,
        output result_uncoded, alu_done, alu_busy, alu_err
    );
endinterface

// File: rtl/seq_calc_alu_iter_core.sv
// -----------------------------------------------------------------------------
// alu_iter_core
//   W-step iteration engine shared by multiply (shift-add) and divide
//   (restoring shift-subtract). One 2W-bit shift register holds
//   {partial/remainder, multiplier/quotient}.
//   Ports: clk, rst (sync, active-high), start (load operands), mode
//   (MODE_MUL / MODE_DIV), a, b (operands at start), done (all W steps
//   complete), result ({hi, lo} of the shift register).
//   mul result = product; div result = {remainder, quotient}.
// -----------------------------------------------------------------------------
module alu_iter_core
    import calc_alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  iter_mode_t     mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] result
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] sr_q, sr_d;
    logic [W-1:0]   opnd_q, opnd_d;
    iter_mode_t     mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   addend;
    logic [W:0]     sum;
    logic [W:0]     trial;
    logic           ge;

    always_comb begin
        // Multiply step: add multiplicand into the upper half, shift right with carry.
        addend = sr_q[0] ? opnd_q : '0;
        sum    = {1'b0, sr_q[2*W-1:W]} + {1'b0, addend};
        // Divide step: remainder shifted left with the next dividend bit.
        trial  = sr_q[2*W-1:W-1];
        ge     = (trial >= {1'b0, opnd_q});

        sr_d   = sr_q;
        opnd_d = opnd_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;

        if (start) begin
            sr_d   = {{W{1'b0}}, (mode == MODE_MUL) ? b : a};
            opnd_d = (mode == MODE_MUL) ? a : b;
            mode_d = mode;
            cnt_d  = CW'(W);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (mode_q == MODE_MUL) begin
                sr_d = {sum, sr_q[W-1:1]};
            end else begin
                // Remainder stays below the divisor, so W-bit wrap-around subtraction is exact.
                sr_d = {(ge ? (trial[W-1:0] - opnd_q) : trial[W-1:0]), sr_q[W-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            opnd_q <= '0;
            mode_q <= MODE_MUL;
            cnt_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            opnd_q <= opnd_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    assign done   = (cnt_q == '0);
    assign result = sr_q;

endmodule

// File: rtl/seq_calc_alu.sv
// -----------------------------------------------------------------------------
// seq_calc_alu
//   Multi-cycle unsigned integer ALU: add, sub, mul, div with start/done/busy
//   handshake and an error flag (divide-by-zero or illegal opcode).
//   Ports: clk, rst (sync, active-high), bus (seq_calc_alu_if.slave):
//     alu_sel/wr_enable start request, first_nr/second_nr operands,
//     operation one-hot opcode, result_uncoded registered 2W-bit result,
//     alu_done one-cycle completion pulse, alu_busy, alu_err.
//   Optional macro ALU_REM_EN: division result carries the remainder in its
//   upper W bits; otherwise the upper bits are zero.
// -----------------------------------------------------------------------------
module seq_calc_alu
    import calc_alu_pkg::*;
#(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_calc_alu_if.slave bus
);
    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [2*W-1:0]  res_q, res_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            core_start;
    logic            core_done;
    iter_mode_t      core_mode;
    logic [2*W-1:0]  core_res;
    logic            iter_op;

    assign accept     = (state_q == ST_IDLE) && bus.alu_sel && bus.wr_enable;
    assign core_mode  = (bus.operation == OPW'(OP_DIV)) ? MODE_DIV : MODE_MUL;
    // Divide by zero never enters the iteration engine.
    assign core_start = accept && ((bus.operation == OPW'(OP_MUL)) ||
                        ((bus.operation == OPW'(OP_DIV)) && (bus.second_nr != '0)));
    assign iter_op    = (op_q == OPW'(OP_MUL)) || ((op_q == OPW'(OP_DIV)) && (b_q != '0));

    alu_iter_core #(.W(W)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .mode   (core_mode),
        .a      (bus.first_nr),
        .b      (bus.second_nr),
        .done   (core_done),
        .result (core_res)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.first_nr;
                    b_d     = bus.second_nr;
                    op_d    = bus.operation;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!iter_op || core_done) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b0;
                case (op_q)
                    OPW'(OP_NOP): res_d = '0;
                    OPW'(OP_ADD): res_d = (2*W)'(a_q) + (2*W)'(b_q);
                    OPW'(OP_SUB): res_d = (2*W)'(a_q) - (2*W)'(b_q);
                    OPW'(OP_MUL): res_d = core_res;
                    OPW'(OP_DIV): begin
                        if (b_q == '0) begin
                            err_d = 1'b1;
`ifdef ALU_REM_EN
                            res_d = {a_q, {W{1'b1}}};
`else
                            res_d = {{W{1'b0}}, {W{1'b1}}};
`endif
                        end else begin
`ifdef ALU_REM_EN
                            res_d = core_res;
`else
                            res_d = {{W{1'b0}}, core_res[W-1:0]};
`endif
                        end
                    end
                    default: begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.result_uncoded = res_q;
    assign bus.alu_done       = done_q;
    assign bus.alu_busy       = (state_q != ST_IDLE);
    assign bus.alu_err        = err_q;

endmodule

// File: tb/tb_seq_calc_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_calc_alu
//   Bench for seq_calc_alu (W=4 main instance, W=8 instance for wide multiply).
//   Honours ALU_REM_EN for the expected division results.
// -----------------------------------------------------------------------------
module tb_seq_calc_alu;
    import calc_alu_pkg::*;

    localparam int W  = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_calc_alu_if #(.W(W),  .OPW(4)) bus  ();
    seq_calc_alu_if #(.W(W8), .OPW(4)) bus8 ();

    seq_calc_alu #(.W(W),  .OPW(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
    seq_calc_alu #(.W(W8), .OPW(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    // Reference: plain arithmetic on integers, latency in cycles from acceptance.
    function automatic void model(input logic [3:0] op, input int unsigned a, input int unsigned b,
                                  input int unsigned w, output logic [31:0] res,
                                  output logic err, output int lat);
        longint unsigned m1 = (64'd1 << w) - 1;
        longint unsigned m2 = (64'd1 << (2 * w)) - 1;
        longint unsigned r  = 0;
        err = 1'b0;
        lat = 2;
        case (op)
            4'b0000: r = 0;
            4'b0001: r = longint'(a) + longint'(b);
            4'b1000: r = longint'(a) - longint'(b);
            4'b0010: begin r = longint'(a) * longint'(b); lat = w + 2; end
            4'b0100: begin
                if (b == 0) begin
                    err = 1'b1;
`ifdef ALU_REM_EN
                    r = (longint'(a) << w) | m1;
`else
                    r = m1;
`endif
                end else begin
                    lat = w + 2;
`ifdef ALU_REM_EN
                    r = (longint'(a % b) << w) | longint'(a / b);
`else
                    r = longint'(a / b);
`endif
                end
            end
            default: begin r = 0; err = 1'b1; end
        endcase
        res = 32'(r & m2);
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        if ($urandom_range(0, 5) == 0) return 4'($urandom_range(0, 15));
        return ops[$urandom_range(0, 4)];
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.operation = op;
        bus.first_nr  = a;
        bus.second_nr = b;
        bus.alu_sel   = 1'b1;
        bus.wr_enable = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.alu_sel   = 1'b0;
        bus.wr_enable = 1'b0;
    endtask

    // Returns just after the acceptance edge T0.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive(op, a, b);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Counts edges after T0 until alu_done; lat = -1 if the budget expires.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = -1;
        busy_ok = (bus.alu_busy === 1'b1);
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.alu_done === 1'b1) begin
                if (bus.alu_busy !== 1'b0) busy_ok = 0;
                lat = i;
                break;
            end else if (bus.alu_busy !== 1'b1) begin
                busy_ok = 0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.result_uncoded, bus.alu_done, bus.alu_busy, bus.alu_err} !== '0) begin
            errors++;
            $display("FAIL reset_w4 got res=%h done=%b busy=%b err=%b want all 0",
                     bus.result_uncoded, bus.alu_done, bus.alu_busy, bus.alu_err);
        end
        checks++;
        if ({bus8.result_uncoded, bus8.alu_done, bus8.alu_busy, bus8.alu_err} !== '0) begin
            errors++;
            $display("FAIL reset_w8 got res=%h done=%b busy=%b err=%b want all 0",
                     bus8.result_uncoded, bus8.alu_done, bus8.alu_busy, bus8.alu_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed list of operations, each checked for result, err, latency and busy.
    task automatic test_directed(input string name, input logic [3:0] op,
                                 input int unsigned a, input int unsigned b);
        int lat; bit bok; logic [31:0] er; logic ee; int el;
        start_op(op, W'(a), W'(b));
        wait_done(lat, bok);
        model(op, a, b, W, er, ee, el);
        checks++;
        if (lat !== el || 32'(bus.result_uncoded) !== er || bus.alu_err !== ee || !bok) begin
            errors++;
            $display("FAIL %s got res=%h err=%b lat=%0d busy_ok=%0d want res=%h err=%b lat=%0d busy_ok=1",
                     name, bus.result_uncoded, bus.alu_err, lat, bok, er, ee, el);
        end
    endtask

    task automatic test_mul_busy_ignore();
        int lat = -1; bit bok = 1; int extra = 0; logic [31:0] er; logic ee; int el;
        @(negedge clk);
        drive(OP_MUL, '1, '1);
        @(posedge clk);
        #1;
        drive(OP_ADD, W'(1), W'(1));
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.alu_done === 1'b1) begin
                idle_inputs();
                lat = i;
                break;
            end else if (bus.alu_busy !== 1'b1) begin
                bok = 0;
            end
        end
        idle_inputs();
        model(OP_MUL, (1 << W) - 1, (1 << W) - 1, W, er, ee, el);
        checks++;
        if (lat !== el || 32'(bus.result_uncoded) !== er || bus.alu_err !== ee || !bok) begin
            errors++;
            $display("FAIL mul_max_busy got res=%h err=%b lat=%0d busy_ok=%0d want res=%h err=%b lat=%0d",
                     bus.result_uncoded, bus.alu_err, lat, bok, er, ee, el);
        end
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.alu_done !== 1'b0 || bus.alu_busy !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL no_queued_start got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int lat; bit bok; logic [31:0] er; logic ee; int el;
        logic [W-1:0] a, b;
        start_op(OP_DIV, W'(9), W'(0));
        wait_done(lat, bok);
        start_op(OP_MUL, '1, W'(3));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.result_uncoded, bus.alu_done, bus.alu_busy, bus.alu_err} !== '0) begin
            errors++;
            $display("FAIL abort_reset got res=%h done=%b busy=%b err=%b want all 0",
                     bus.result_uncoded, bus.alu_done, bus.alu_busy, bus.alu_err);
        end
        a = W'($urandom);
        b = W'($urandom);
        start_op(OP_MUL, a, b);
        wait_done(lat, bok);
        model(OP_MUL, a, b, W, er, ee, el);
        checks++;
        if (lat !== el || 32'(bus.result_uncoded) !== er || bus.alu_err !== ee || !bok) begin
            errors++;
            $display("FAIL after_abort got res=%h err=%b lat=%0d want res=%h err=%b lat=%0d",
                     bus.result_uncoded, bus.alu_err, lat, er, ee, el);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; logic [31:0] er; logic ee; int el;
        logic [3:0] op; logic [W-1:0] a, b;
        op = rand_op(); a = W'($urandom); b = W'($urandom);
        start_op(op, a, b);
        for (int k = 0; k < 8; k++) begin
            wait_done(lat, bok);
            model(op, a, b, W, er, ee, el);
            checks++;
            if (lat !== el || 32'(bus.result_uncoded) !== er || bus.alu_err !== ee || !bok) begin
                errors++;
                $display("FAIL b2b_%0d op=%b a=%0d b=%0d got res=%h err=%b lat=%0d want res=%h err=%b lat=%0d",
                         k, op, a, b, bus.result_uncoded, bus.alu_err, lat, er, ee, el);
            end
            if (k < 7) begin
                op = rand_op(); a = W'($urandom); b = W'($urandom);
                drive(op, a, b);
                @(posedge clk);
                #1;
                idle_inputs();
                checks++;
                if (32'(bus.result_uncoded) !== er || bus.alu_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_hold_%0d got res=%h busy=%b want res=%h busy=1",
                             k, bus.result_uncoded, bus.alu_busy, er);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat; bit bok; logic [31:0] er; logic ee; int el;
        logic [3:0] op; logic [W-1:0] a, b;
        for (int k = 0; k < 30; k++) begin
            op = rand_op(); a = W'($urandom); b = W'($urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            start_op(op, a, b);
            wait_done(lat, bok);
            model(op, a, b, W, er, ee, el);
            checks++;
            if (lat !== el || 32'(bus.result_uncoded) !== er || bus.alu_err !== ee || !bok) begin
                errors++;
                $display("FAIL rand_%0d op=%b a=%0d b=%0d got res=%h err=%b lat=%0d want res=%h err=%b lat=%0d",
                         k, op, a, b, bus.result_uncoded, bus.alu_err, lat, er, ee, el);
            end
        end
    endtask

    task automatic test_mul_w8();
        int lat; int unsigned a, b;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 255 : $urandom_range(0, 255);
            b = (k == 0) ? 255 : $urandom_range(0, 255);
            @(negedge clk);
            bus8.operation = OP_MUL;
            bus8.first_nr  = W8'(a);
            bus8.second_nr = W8'(b);
            bus8.alu_sel   = 1'b1;
            bus8.wr_enable = 1'b1;
            @(posedge clk);
            #1;
            bus8.alu_sel   = 1'b0;
            bus8.wr_enable = 1'b0;
            lat = -1;
            for (int i = 1; i <= 60; i++) begin
                @(posedge clk);
                #1;
                if (bus8.alu_done === 1'b1) begin lat = i; break; end
            end
            checks++;
            if (lat !== W8 + 2 || 32'(bus8.result_uncoded) !== 32'(a * b) || bus8.alu_err !== 1'b0) begin
                errors++;
                $display("FAIL mul_w8_%0d a=%0d b=%0d got res=%h err=%b lat=%0d want res=%h err=0 lat=%0d",
                         k, a, b, bus8.result_uncoded, bus8.alu_err, lat, 32'(a * b), W8 + 2);
            end
        end
    endtask

    initial begin
        bus.alu_sel = 1'b0;  bus.wr_enable = 1'b0;  bus.first_nr = '0;  bus.second_nr = '0;  bus.operation = '0;
        bus8.alu_sel = 1'b0; bus8.wr_enable = 1'b0; bus8.first_nr = '0; bus8.second_nr = '0; bus8.operation = '0;

        test_reset();
        test_directed("add_7_5",  OP_ADD, 7, 5);
        test_directed("sub_3_9",  OP_SUB, 3, 9);
        test_directed("sub_9_3",  OP_SUB, 9, 3);
        test_mul_busy_ignore();
        test_directed("div_13_4", OP_DIV, 13, 4);
        test_directed("div_15_1", OP_DIV, 15, 1);
        test_directed("div_9_0",  OP_DIV, 9, 0);
        test_directed("add_1_1",  OP_ADD, 1, 1);
        test_directed("nop",      OP_NOP, 6, 2);
        test_directed("illegal",  4'b0011, 6, 2);
        test_directed("add_max",  OP_ADD, 15, 15);
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_mul_w8();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
